// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls words from a registered-read FIFO: 2 cycles from the read request to the start bit, CLKS_PER_BIT cycles per bit.
// tx_en gates only the start of a frame; a frame in flight always runs to its stop bit.
module fifo_uart_tx #(
   parameter int WIDTH        = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tx_en,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] fifo_data,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic [15:0]      frame_count
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shreg_nxt;
   logic [CW-1:0]    clk_cnt;
   logic [IW-1:0]    bit_idx;
   logic             bit_done;

   assign fifo_rd_en = (state == IDLE) && tx_en && !fifo_empty && !rst;
   assign bit_done   = (clk_cnt == CNT_MAX);
   assign shreg_nxt  = shreg >> 1;

   // tx is loaded one edge ahead with the level of the segment being entered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tx          <= 1'b1;
         busy        <= 1'b0;
         frame_count <= 16'd0;
         shreg       <= '0;
         clk_cnt     <= '0;
         bit_idx     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (fifo_rd_en) begin
                  state <= LOAD;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               shreg   <= fifo_data;
               clk_cnt <= '0;
               tx      <= 1'b0;
               state   <= START;
            end
            START: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  tx      <= shreg[0];
                  state   <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            DATA: begin
               if (bit_done) begin
                  clk_cnt <= '0;
                  if (bit_idx == IDX_MAX) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + IW'(1);
                     shreg   <= shreg_nxt;
                     tx      <= shreg_nxt[0];
                  end
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            STOP: begin
               if (bit_done) begin
                  clk_cnt     <= '0;
                  busy        <= 1'b0;
                  frame_count <= frame_count + 16'd1;
                  state       <= IDLE;
               end else begin
                  clk_cnt <= clk_cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: lane 0 at 4 clocks/bit, lane 1 at 1 clock/bit, each fed by a queue-backed FIFO.
// Expected line levels come from a frame-position model: LOAD cycle, then start, data LSB first, stop.
module tb_fifo_uart_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst_l;
   logic [1:0]       tx_en_l;
   logic [1:0]       fifo_empty_l;
   logic [1:0][7:0]  fifo_data_l;
   logic [1:0]       rd_l;
   logic [1:0]       tx_l;
   logic [1:0]       busy_l;
   logic [1:0][15:0] fc_l;

   fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4)) dut0 (
      .clk(clk), .rst(rst_l[0]), .tx_en(tx_en_l[0]), .fifo_empty(fifo_empty_l[0]),
      .fifo_data(fifo_data_l[0]), .fifo_rd_en(rd_l[0]), .tx(tx_l[0]),
      .busy(busy_l[0]), .frame_count(fc_l[0]));

   fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
      .clk(clk), .rst(rst_l[1]), .tx_en(tx_en_l[1]), .fifo_empty(fifo_empty_l[1]),
      .fifo_data(fifo_data_l[1]), .fifo_rd_en(rd_l[1]), .tx(tx_l[1]),
      .busy(busy_l[1]), .frame_count(fc_l[1]));

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];
   int gaps0[$];
   int gaps1[$];
   int last_rd[2];
   int rd_cnt[2];

   bit         m_active[2];
   int         m_pos[2];
   logic [7:0] m_byte[2];
   logic [15:0] m_count[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic int cpb_of(input int l);
      return (l == 0) ? 4 : 1;
   endfunction

   function automatic int qsize(input int l);
      if (l == 0) return q0.size();
      return q1.size();
   endfunction

   function automatic logic [7:0] qfront(input int l);
      if (l == 0) return q0[0];
      return q1[0];
   endfunction

   function automatic logic [7:0] qpop(input int l);
      if (l == 0) return q0.pop_front();
      return q1.pop_front();
   endfunction

   task automatic push(input int l, input logic [7:0] d);
      if (l == 0) q0.push_back(d);
      else q1.push_back(d);
   endtask

   // Line level for the cycle at position pos of a frame (pos 0 = LOAD).
   function automatic logic exp_tx(input int l);
      int b;
      if (!m_active[l] || m_pos[l] == 0) return 1'b1;
      b = (m_pos[l] - 1) / cpb_of(l);
      if (b == 0) return 1'b0;
      if (b <= 8) return m_byte[l][b-1];
      return 1'b1;
   endfunction

   task automatic tick();
      logic [1:0] exp_rd;
      logic [1:0] rd_obs;
      logic [1:0] upd;
      logic [7:0] nd[2];
      for (int l = 0; l < 2; l++) fifo_empty_l[l] = (qsize(l) == 0);
      @(negedge clk);
      for (int l = 0; l < 2; l++) begin
         exp_rd[l] = !m_active[l] && tx_en_l[l] && !fifo_empty_l[l] && !rst_l[l];
         rd_obs[l] = rd_l[l];
         check($sformatf("rd_en[%0d]", l), rd_l[l], exp_rd[l]);
         check($sformatf("tx[%0d]", l), tx_l[l], exp_tx(l));
         check($sformatf("busy[%0d]", l), busy_l[l], m_active[l]);
         check($sformatf("frame_count[%0d]", l), fc_l[l], m_count[l]);
         if (rd_obs[l]) begin
            rd_cnt[l]++;
            if (last_rd[l] >= 0) begin
               if (l == 0) gaps0.push_back(cyc - last_rd[l]);
               else gaps1.push_back(cyc - last_rd[l]);
            end
            last_rd[l] = cyc;
         end
      end
      @(posedge clk);
      upd = '0;
      for (int l = 0; l < 2; l++) begin
         if (rst_l[l]) begin
            m_active[l] = 1'b0;
            m_pos[l]    = 0;
            m_count[l]  = 16'd0;
         end else if (m_active[l]) begin
            if (m_pos[l] == 10 * cpb_of(l)) begin
               m_active[l] = 1'b0;
               m_count[l]  = m_count[l] + 16'd1;
            end else begin
               m_pos[l]++;
            end
         end else if (exp_rd[l]) begin
            m_active[l] = 1'b1;
            m_pos[l]    = 0;
            m_byte[l]   = qfront(l);
         end
         if (rd_obs[l] && qsize(l) > 0) begin
            nd[l]  = qpop(l);
            upd[l] = 1'b1;
         end
      end
      #1;
      for (int l = 0; l < 2; l++) if (upd[l]) fifo_data_l[l] = nd[l];
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_l        = 2'b11;
      tx_en_l      = 2'b00;
      fifo_empty_l = 2'b11;
      fifo_data_l  = '0;
      for (int l = 0; l < 2; l++) begin
         m_active[l] = 1'b0;
         m_pos[l]    = 0;
         m_byte[l]   = 8'h00;
         m_count[l]  = 16'd0;
         last_rd[l]  = -1;
         rd_cnt[l]   = 0;
      end
      @(posedge clk);
      #1;

      // Reset held with a non-empty FIFO and permission granted.
      push(0, 8'h11);
      tx_en_l[0] = 1'b1;
      run(2);
      q0.delete();
      tx_en_l[0] = 1'b0;
      run(1);
      rst_l[0] = 1'b0;
      run(2);

      // Single byte 0xA5.
      rd_cnt[0] = 0;
      push(0, 8'hA5);
      tx_en_l[0] = 1'b1;
      run(50);
      check("single_frames", fc_l[0], 16'd1);
      check("single_reads", rd_cnt[0], 1);

      // Back-to-back 0x01, 0x80, 0xFF.
      rd_cnt[0]  = 0;
      last_rd[0] = -1;
      gaps0.delete();
      push(0, 8'h01);
      push(0, 8'h80);
      push(0, 8'hFF);
      run(134);
      check("b2b_frames", fc_l[0], 16'd4);
      check("b2b_reads", rd_cnt[0], 3);
      check("b2b_gap_count", gaps0.size(), 2);
      foreach (gaps0[i]) check("b2b_gap", gaps0[i], 42);

      // Enable gate: no read while disabled, then drop enable mid-DATA.
      tx_en_l[0] = 1'b0;
      push(0, 8'h3C);
      push(0, 8'h77);
      run(20);
      tx_en_l[0] = 1'b1;
      run(10);
      tx_en_l[0] = 1'b0;
      run(45);
      check("gate_frames", fc_l[0], 16'd5);
      check("gate_left_in_fifo", qsize(0), 1);

      // Reset in data bit 3 of 0xF0, then a clean frame.
      q0.delete();
      push(0, 8'hF0);
      tx_en_l[0] = 1'b1;
      run(19);
      rst_l[0]   = 1'b1;
      tx_en_l[0] = 1'b0;
      run(1);
      rst_l[0] = 1'b0;
      run(3);
      check("midrst_frames", fc_l[0], 16'd0);
      push(0, 8'h5A);
      tx_en_l[0] = 1'b1;
      run(46);
      check("after_rst_frames", fc_l[0], 16'd1);

      // One clock per bit: 0x55 twice back-to-back.
      rst_l[1] = 1'b0;
      run(1);
      last_rd[1] = -1;
      gaps1.delete();
      push(1, 8'h55);
      push(1, 8'h55);
      tx_en_l[1] = 1'b1;
      run(30);
      check("min_frames", fc_l[1], 16'd2);
      check("min_gap_count", gaps1.size(), 1);
      foreach (gaps1[i]) check("min_gap", gaps1[i], 12);

      // Random traffic on both lanes: enable flicker, sporadic pushes, rare resets.
      for (int i = 0; i < 800; i++) begin
         for (int l = 0; l < 2; l++) begin
            tx_en_l[l] = ($urandom_range(0, 9) != 0);
            rst_l[l]   = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, (l == 0) ? 40 : 10) == 0)
               push(l, 8'($urandom_range(0, 255)));
         end
         tick();
      end
      rst_l   = 2'b00;
      tx_en_l = 2'b00;
      run(50);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bits per frame (matches upstream FIFO word width).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit; legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port tx_en  input  1  permission to start a new frame.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port fifo_data  input  WIDTH  upstream FIFO registered read data, valid the cycle after a read.
REQ-008 SHALL have port fifo_rd_en  output  1  one-cycle read request to the upstream FIFO.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high from the LOAD state through the last STOP cycle.
REQ-011 SHALL have port frame_count  output  16  count of completed frames, wraps 0xFFFF->0x0000.

Function
REQ-012 SHALL implement states IDLE, LOAD, START, DATA, STOP.
REQ-013 SHALL drive fifo_rd_en combinationally = (state==IDLE) & tx_en & ~fifo_empty & ~rst; never high in any other state.
REQ-014 SHALL go IDLE->LOAD on the edge where fifo_rd_en is high; otherwise remain in IDLE.
REQ-015 SHALL, in LOAD (exactly 1 cycle), capture fifo_data into the shift register and go to START.
REQ-016 SHALL drive tx=0 for exactly CLKS_PER_BIT cycles in START, then go to DATA.
REQ-017 SHALL, in DATA, output WIDTH bits LSB first, each held exactly CLKS_PER_BIT cycles, then go to STOP.
REQ-018 SHALL drive tx=1 for exactly CLKS_PER_BIT cycles in STOP; on the final STOP cycle, increment frame_count and go to IDLE.
REQ-019 SHALL drive tx=1 in IDLE and LOAD.
REQ-020 SHALL drive tx from a register; tx changes only on clock edges.
REQ-021 SHALL sample tx_en only in IDLE; deasserting tx_en mid-frame SHALL NOT shorten or abort the current frame.
REQ-022 SHALL ignore fifo_empty and fifo_data outside IDLE/LOAD.
REQ-023 SHALL produce a first-frame latency of 2 cycles, from the rd_en edge to the first START cycle (IDLE cycle, LOAD cycle).
REQ-024 SHALL produce a back-to-back period of CLKS_PER_BIT*(WIDTH+2)+2 cycles per frame, with exactly 2 idle-high cycles (IDLE, LOAD) between the end of STOP and the next START.
REQ-025 SHALL size the bit-period counter for CLKS_PER_BIT-1 and the bit index for WIDTH-1, without overflow at the maxima.
REQ-026 SHALL at most one fifo_rd_en pulse per frame; SHALL never read the FIFO while fifo_empty=1.

Reset
REQ-027 SHALL, with rst high at a clock edge, set state=IDLE, tx=1, busy=0, frame_count=0, shift register=0, counters=0.
REQ-028 SHALL hold fifo_rd_en=0 while rst is high.
REQ-029 SHALL, on reset mid-frame, discard the partial frame, drive tx=1 from the next edge, and not count the partial frame.

Verification (WIDTH=8, CLKS_PER_BIT=4)
REQ-030 SHALL cover reset: assert rst 2 cycles with FIFO non-empty -> tx=1, busy=0, frame_count=0, fifo_rd_en=0 throughout.
REQ-031 SHALL cover a single byte: FIFO holds 0xA5, tx_en=1 -> one rd_en pulse; START 2 cycles later; tx sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles per bit (42 cycles total); frame_count=1; back in IDLE, no further rd_en.
REQ-032 SHALL cover back-to-back bytes: FIFO holds 0x01,0x80,0xFF -> 3 rd_en pulses 42 cycles apart; exactly 2 high cycles between each STOP and the next START; frame_count=3; LSB-first bits verified per byte.
REQ-033 SHALL cover the enable gate: tx_en=0, FIFO non-empty for 20 cycles -> no rd_en, tx=1; then drop tx_en during DATA of byte 0x3C -> frame completes intact and no next read occurs.
REQ-034 SHALL cover reset mid-frame: rst high in bit 3 of DATA of 0xF0 -> tx=1 on the next edge, frame_count=0, and the next frame starts cleanly from IDLE.
REQ-035 SHALL cover the minimum bit period: CLKS_PER_BIT=1, byte 0x55 -> 10 one-cycle bits 0,1,0,1,0,1,0,1,0,1; period 12 cycles back-to-back.
